stream_sample_player: RTL and testbench
=======================================

Name: stream_sample_player

Overview:
- Synthesizable, parametrised successor to the bench-side input driver that replays a stored signal into an FFT stream.
- Holds DEPTH samples of WIDTH bits in on-chip RAM, loaded through a write port.
- Replays them as frames on a valid/ready source interface, compatible with the dstream convention used by fft_stream.
- Adds what the bench driver lacks: programmable frame length, finite or infinite frame count, stop control, last-sample marker and status.

Parameters:
WIDTH, 32, sample width in bits
DEPTH, 1024, sample RAM depth; power of two, at least 4
AW, $clog2(DEPTH), address width (derived)
CW, 16, frame-count width

Ports:
clk  input  1  master clock
reset  input  1  asynchronous active-high reset
wr_en  input  1  RAM write strobe; ignored while busy=1
wr_addr  input  AW  RAM write address
wr_data  input  WIDTH  RAM write data
start  input  1  begin playback; sampled in IDLE only
stop  input  1  request end of playback after the current handshake
frame_len  input  AW+1  samples per frame, 1..DEPTH; 0 or >DEPTH means DEPTH; latched at start
num_frames  input  CW  frames to play; 0 means infinite; latched at start
y_data  output  WIDTH  sample out
y_valid  output  1  sample valid
y_ready  input  1  downstream ready
y_last  output  1  high with the final sample of each frame
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse on the handshake of a y_last sample
frames_played  output  CW  completed frames since the last start; saturates at all-ones

Behaviour:
- Reset (async, active-high): state=IDLE; y_valid=0, y_last=0, y_data=0, busy=0, frame_done=0, frames_played=0, read address=0. RAM contents are undefined after reset and are not cleared.
- RAM: one write port, one synchronous read port (1-cycle latency). Write and read hit the same clk edge.
- Handshake: a transfer occurs on a rising clk edge with y_valid && y_ready.
  - Once y_valid rises, y_data, y_last and y_valid stay stable until that transfer completes.
  - y_valid never depends combinationally on y_ready.
- RAM read address mux: next address on a handshake, otherwise the current address. This keeps a new sample presented every cycle while y_ready=1, giving full throughput of 1 sample/clk.
- States:
  - IDLE: start=1 -> latch frame_len and num_frames; clear frames_played; addr=0; go to PRIME.
  - PRIME: one cycle for the RAM read of address 0 -> STREAM, with y_valid=1 at the next edge. Start-to-first-valid latency is 2 clocks.
  - STREAM, on each handshake:
    - addr increments.
    - If addr==len-1: y_last is high on this sample; frames_played++; frame_done pulses the next cycle; addr wraps to 0.
    - If frames_played+1==num_frames (num_frames!=0), or stop is pending: go to DRAIN.
    - Otherwise stay in STREAM; the next frame follows with no bubble.
  - DRAIN: y_valid=0 and y_last=0 -> IDLE next cycle.
- stop:
  - Registered as a pending flag.
  - Playback ends after the next handshake, mid-frame allowed; y_last is not forced.
  - stop asserted together with start in IDLE: start wins; stop is ignored.
- Guards: start while busy is ignored. wr_en while busy is ignored; no RAM write occurs.
- frame_len=1: y_last is high on every sample; addr stays 0.
- Infinite mode: frames_played saturates at 2^CW-1 and never wraps.
- Reset mid-stream: all outputs return to reset values immediately (asynchronous); no partial handshake completes.

Optional Feature:
Macro SAMPLE_PLAYER_GAP_EN.
- Defined:
  - Adds input gap_cycles [15:0], latched at start, and state GAP.
  - After each y_last handshake that does not end playback, the block enters GAP with y_valid=0 for exactly gap_cycles clocks, then returns to STREAM.
  - The sample at address 0 is valid on the cycle after GAP exits.
  - gap_cycles=0 behaves exactly as when undefined.
  - stop during GAP -> DRAIN next cycle.
- Undefined: no gap_cycles port and no GAP state; frames are back-to-back.

Test Plan:
- DEPTH=8, WIDTH=16; load RAM[i]=0x1000+i; start with frame_len=8, num_frames=1, y_ready=1 -> y_valid rises 2 clocks after start; data 0x1000..0x1007 on consecutive clocks; y_last only on 0x1007; frame_done pulses once; busy drops within 2 clocks; frames_played=1.
- Same load; frame_len=3, num_frames=2 -> sequence 0x1000,1001,1002(last),1000,1001,1002(last); frames_played=2; 2 frame_done pulses.
- Backpressure: y_ready toggles 1,0,0,1,... -> y_data holds during ready=0; no sample dropped or duplicated; output order equals RAM order.
- Infinite mode, num_frames=0, frame_len=4; assert stop after 6 handshakes -> exactly 7 samples transferred (0x1000..1003,1000..1002); busy clears; frames_played=1.
- Attempt wr_en to address 2 while busy, and start pulse while busy -> RAM[2] unchanged on next run; no restart mid-stream.
- Assert reset during STREAM -> y_valid=0, busy=0 and frames_played=0 asynchronously; a subsequent start replays from 0x1000.

Source files
------------

// File: rtl/stream_sample_player.sv
// stream_sample_player
//   Replays DEPTH stored samples of WIDTH bits as frames on a valid/ready
//   source stream (dstream convention). The RAM is loaded through a write
//   port while the player is idle. Frame length, frame count (0 = infinite),
//   stop control, last-sample marker and status are provided.
//
// Optional feature: define SAMPLE_PLAYER_GAP_EN to add the gap_cycles input
//   and a GAP state that inserts idle cycles between frames.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   wr_en/addr/data   RAM write port (ignored while busy)
//   start, stop       begin playback (IDLE only) / end after current handshake
//   frame_len         samples per frame; 0 or >DEPTH selects DEPTH
//   num_frames        frames to play; 0 = infinite
//   gap_cycles        idle cycles between frames (SAMPLE_PLAYER_GAP_EN only)
//   y_data/valid/last source stream, y_ready from downstream
//   busy              high whenever not IDLE
//   frame_done        one-cycle pulse after a y_last handshake
//   frames_played     completed frames since start, saturating
module stream_sample_player #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             stop,
  input  logic [AW:0]      frame_len,
  input  logic [CW-1:0]    num_frames,
`ifdef SAMPLE_PLAYER_GAP_EN
  input  logic [15:0]      gap_cycles,
`endif
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             y_last,
  output logic             busy,
  output logic             frame_done,
  output logic [CW-1:0]    frames_played
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DRAIN
`ifdef SAMPLE_PLAYER_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    addr;
  logic [AW-1:0]    len_m1;
  logic [CW-1:0]    nfr_q;
  logic             stop_pend;

  logic [AW:0]      eff_len;
  logic [AW-1:0]    next_addr;
  logic [AW-1:0]    rd_addr;
  logic             hs;
  logic             last_frame;
  logic             stop_req;

`ifdef SAMPLE_PLAYER_GAP_EN
  logic [15:0]      gap_len;
  logic [15:0]      gap_cnt;
`endif

  always_comb begin
    eff_len = frame_len;
    if (frame_len == '0 || frame_len > (AW+1)'(DEPTH))
      eff_len = (AW+1)'(DEPTH);
  end

  assign hs        = y_valid & y_ready;
  assign next_addr = (addr == len_m1) ? '0 : addr + AW'(1);
  // Re-reading the current address while stalled keeps y_data stable; moving
  // to the next address on a handshake gives one sample per clock.
  assign rd_addr   = hs ? next_addr : addr;
  assign last_frame = (nfr_q != '0) &&
                      (({1'b0, frames_played} + (CW+1)'(1)) == {1'b0, nfr_q});
  assign stop_req  = stop | stop_pend;

  always_ff @(posedge clk) begin
    if (wr_en && !busy)
      mem[wr_addr] <= wr_data;
  end

  // Synchronous read port doubles as the y_data output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      y_data <= '0;
    else
      y_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      y_valid       <= 1'b0;
      y_last        <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frames_played <= '0;
      addr          <= '0;
      len_m1        <= '0;
      nfr_q         <= '0;
      stop_pend     <= 1'b0;
`ifdef SAMPLE_PLAYER_GAP_EN
      gap_len       <= '0;
      gap_cnt       <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            len_m1        <= AW'(eff_len - (AW+1)'(1));
            nfr_q         <= num_frames;
            frames_played <= '0;
            addr          <= '0;
            stop_pend     <= 1'b0;
            busy          <= 1'b1;
`ifdef SAMPLE_PLAYER_GAP_EN
            gap_len       <= gap_cycles;
`endif
            state         <= S_PRIME;
          end
        end
        S_PRIME: begin
          stop_pend <= stop;
          y_valid   <= 1'b1;
          y_last    <= (len_m1 == '0);
          state     <= S_STREAM;
        end
        S_STREAM: begin
          if (hs) begin
            addr <= next_addr;
            if (y_last) begin
              if (frames_played != '1)
                frames_played <= frames_played + CW'(1);
              frame_done <= 1'b1;
            end
            if (stop_req || (y_last && last_frame)) begin
              y_valid <= 1'b0;
              y_last  <= 1'b0;
              state   <= S_DRAIN;
            end
`ifdef SAMPLE_PLAYER_GAP_EN
            else if (y_last && gap_len != '0) begin
              y_valid <= 1'b0;
              y_last  <= 1'b0;
              gap_cnt <= gap_len;
              state   <= S_GAP;
            end
`endif
            else begin
              y_last <= (next_addr == len_m1);
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
        S_DRAIN: begin
          busy      <= 1'b0;
          stop_pend <= 1'b0;
          state     <= S_IDLE;
        end
`ifdef SAMPLE_PLAYER_GAP_EN
        // addr is already 0 here, so mem[0] is in y_data when GAP exits.
        S_GAP: begin
          if (stop) begin
            state <= S_DRAIN;
          end else if (gap_cnt == 16'd1) begin
            y_valid <= 1'b1;
            y_last  <= (len_m1 == '0);
            state   <= S_STREAM;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sample_player.sv
// Testbench for stream_sample_player (DEPTH=8, WIDTH=16, CW=4).
// Expected streams come from a plain model: sample k of a run is
// mem[k % L], last when k % L == L-1, run length = frames*L capped by stop.
module tb_stream_sample_player;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [AW:0]      frame_len = '0;
  logic [CW-1:0]    num_frames = '0;
  logic             y_ready = 1'b0;
  logic [WIDTH-1:0] y_data;
  logic             y_valid;
  logic             y_last;
  logic             busy;
  logic             frame_done;
  logic [CW-1:0]    frames_played;
`ifdef SAMPLE_PLAYER_GAP_EN
  logic [15:0]      gap_cycles = '0;
`endif

  always #5 clk = ~clk;

  stream_sample_player #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .frame_len(frame_len), .num_frames(num_frames),
`ifdef SAMPLE_PLAYER_GAP_EN
    .gap_cycles(gap_cycles),
`endif
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .y_last(y_last),
    .busy(busy), .frame_done(frame_done), .frames_played(frames_played)
  );

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] mem_m [DEPTH];
  logic [WIDTH-1:0] got_d [$];
  logic             got_l [$];
  int fd_cnt, fd_err, stable_err, first_valid, drop_lat, timed_out, busy_err;

  // ---------------- reference model ----------------
  function automatic int eff_of(input logic [AW:0] flen);
    int f = int'(flen);
    if (f == 0 || f > DEPTH) return DEPTH;
    return f;
  endfunction

  function automatic int exp_total(input logic [AW:0] flen, input logic [CW-1:0] nfr,
                                   input int stop_at);
    int nat = (nfr == 0) ? (1 << 30) : int'(nfr) * eff_of(flen);
    if (stop_at >= 0 && stop_at + 1 < nat) return stop_at + 1;
    return nat;
  endfunction

  function automatic int exp_frames(input int total, input int eff);
    int f = total / eff;
    return (f > (1 << CW) - 1) ? (1 << CW) - 1 : f;
  endfunction

  // Index of the first received sample that disagrees with the model, or -1.
  function automatic int seq_mismatch(input int eff);
    for (int k = 0; k < got_d.size(); k++) begin
      if (got_d[k] !== mem_m[k % eff] || got_l[k] !== ((k % eff) == eff - 1))
        return k;
    end
    return -1;
  endfunction

  function automatic logic ready_for(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (n % 3) == 0;
    return $urandom_range(0, 9) < 6;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_ram(input int random_data);
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = random_data != 0 ? WIDTH'($urandom) : WIDTH'(16'h1000 + i);
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = mem_m[i];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  // Runs one playback and records transfers and status observations.
  task automatic play(input logic [AW:0] flen, input logic [CW-1:0] nfr, input int rmode,
                      input int stop_at, input int inj_at);
    int hs_cnt = 0, edge_n = 0, last_hs_edge = 0;
    logic stalled = 1'b0, pend_fd = 1'b0, hs_now, hold_l, stop_sent = 1'b0, inj_sent = 1'b0;
    logic [WIDTH-1:0] hold_d;
    got_d.delete(); got_l.delete();
    fd_cnt = 0; fd_err = 0; stable_err = 0; first_valid = -1; drop_lat = -1;
    timed_out = 1; busy_err = 0;
    frame_len = flen; num_frames = nfr; start = 1'b1; y_ready = ready_for(rmode, 0);
    @(posedge clk); #1;
    start = 1'b0; edge_n = 1;
    if (busy !== 1'b1) busy_err++;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      hs_now = y_valid && y_ready;
      if (stalled && (y_valid !== 1'b1 || y_data !== hold_d || y_last !== hold_l))
        stable_err++;
      stalled = y_valid && !y_ready;
      hold_d = y_data; hold_l = y_last;
      if (hs_now) begin
        got_d.push_back(y_data); got_l.push_back(y_last); hs_cnt++;
      end
      pend_fd = hs_now && y_last;
      @(posedge clk); #1;
      edge_n++;
      if (hs_now) last_hs_edge = edge_n;
      if (frame_done !== pend_fd) fd_err++;
      if (frame_done === 1'b1) fd_cnt++;
      if (y_valid === 1'b1 && first_valid < 0) first_valid = edge_n;
      stop = 1'b0; wr_en = 1'b0; start = 1'b0;
      if (busy === 1'b0) begin
        timed_out = 0; drop_lat = edge_n - last_hs_edge;
        break;
      end
      if (stop_at >= 0 && !stop_sent && hs_cnt == stop_at) begin
        stop = 1'b1; stop_sent = 1'b1;
      end
      if (inj_at >= 0 && !inj_sent && hs_cnt == inj_at) begin
        wr_en = 1'b1; wr_addr = AW'(2); wr_data = 16'hBEEF; start = 1'b1; inj_sent = 1'b1;
      end
      y_ready = ready_for(rmode, edge_n);
    end
    stop = 1'b0; wr_en = 1'b0; start = 1'b0; y_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 reset = 1'b1;
    #10;
    tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", y_valid); end
    tests++; if (y_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b expected 0", y_last); end
    tests++; if (y_data !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", y_data); end
    tests++; if (busy !== 1'b0 || frame_done !== 1'b0) begin fails++; $display("FAIL reset_status: busy %b frame_done %b expected 0 0", busy, frame_done); end
    tests++; if (frames_played !== '0) begin fails++; $display("FAIL reset_frames: got %0d expected 0", frames_played); end
    #3 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    int mm;
    load_ram(0);
    play(4'd8, 4'd1, 0, -1, -1);
    mm = seq_mismatch(8);
    tests++; if (timed_out != 0) begin fails++; $display("FAIL single_timeout: got %0d expected 0", timed_out); end
    tests++; if (first_valid != 2) begin fails++; $display("FAIL single_latency: got %0d expected 2", first_valid); end
    tests++; if (got_d.size() != 8) begin fails++; $display("FAIL single_count: got %0d expected 8", got_d.size()); end
    tests++; if (mm != -1) begin fails++; $display("FAIL single_seq: mismatch at %0d expected -1", mm); end
    tests++; if (fd_cnt != 1 || fd_err != 0) begin fails++; $display("FAIL single_frame_done: pulses %0d timing errs %0d expected 1 0", fd_cnt, fd_err); end
    tests++; if (drop_lat < 1 || drop_lat > 2) begin fails++; $display("FAIL single_busy_drop: got %0d expected 1..2", drop_lat); end
    tests++; if (frames_played !== 4'd1 || busy_err != 0) begin fails++; $display("FAIL single_frames: got %0d busy_err %0d expected 1 0", frames_played, busy_err); end
  endtask

  task automatic test_multi_frame();
    int mm;
    play(4'd3, 4'd2, 0, -1, -1);
    mm = seq_mismatch(3);
    tests++; if (got_d.size() != 6) begin fails++; $display("FAIL multi_count: got %0d expected 6", got_d.size()); end
    tests++; if (mm != -1) begin fails++; $display("FAIL multi_seq: mismatch at %0d expected -1", mm); end
    tests++; if (frames_played !== 4'd2 || fd_cnt != 2) begin fails++; $display("FAIL multi_frames: got %0d pulses %0d expected 2 2", frames_played, fd_cnt); end
  endtask

  task automatic test_backpressure();
    int mm;
    play(4'd8, 4'd2, 1, -1, -1);
    mm = seq_mismatch(8);
    tests++; if (got_d.size() != 16) begin fails++; $display("FAIL bp_count: got %0d expected 16", got_d.size()); end
    tests++; if (mm != -1) begin fails++; $display("FAIL bp_seq: mismatch at %0d expected -1", mm); end
    tests++; if (stable_err != 0 || fd_err != 0) begin fails++; $display("FAIL bp_stable: hold errs %0d frame_done errs %0d expected 0 0", stable_err, fd_err); end
  endtask

  task automatic test_stop_infinite();
    int mm;
    play(4'd4, 4'd0, 0, 6, -1);
    mm = seq_mismatch(4);
    tests++; if (got_d.size() != 7 || timed_out != 0) begin fails++; $display("FAIL stop_count: got %0d timeout %0d expected 7 0", got_d.size(), timed_out); end
    tests++; if (mm != -1) begin fails++; $display("FAIL stop_seq: mismatch at %0d expected -1", mm); end
    tests++; if (frames_played !== 4'd1) begin fails++; $display("FAIL stop_frames: got %0d expected 1", frames_played); end
  endtask

  task automatic test_guards();
    int mm;
    play(4'd8, 4'd1, 0, -1, 3);
    mm = seq_mismatch(8);
    tests++; if (got_d.size() != 8 || mm != -1) begin fails++; $display("FAIL guard_no_restart: count %0d mismatch %0d expected 8 -1", got_d.size(), mm); end
    play(4'd8, 4'd1, 2, -1, -1);
    tests++; if (got_d.size() < 3 || got_d[2] !== mem_m[2]) begin fails++; $display("FAIL guard_ram2: got %h expected %h", got_d.size() < 3 ? 16'hxxxx : got_d[2], mem_m[2]); end
  endtask

  task automatic test_len_edges();
    int mm;
    play(4'd1, 4'd3, 2, -1, -1);
    mm = seq_mismatch(1);
    tests++; if (got_d.size() != 3 || mm != -1) begin fails++; $display("FAIL len1: count %0d mismatch %0d expected 3 -1", got_d.size(), mm); end
    tests++; if (frames_played !== 4'd3) begin fails++; $display("FAIL len1_frames: got %0d expected 3", frames_played); end
    play(4'd0, 4'd1, 0, -1, -1);
    mm = seq_mismatch(8);
    tests++; if (got_d.size() != 8 || mm != -1) begin fails++; $display("FAIL len0: count %0d mismatch %0d expected 8 -1", got_d.size(), mm); end
    play(4'd12, 4'd1, 0, -1, -1);
    mm = seq_mismatch(8);
    tests++; if (got_d.size() != 8 || mm != -1) begin fails++; $display("FAIL len_over: count %0d mismatch %0d expected 8 -1", got_d.size(), mm); end
  endtask

  task automatic test_saturation();
    play(4'd1, 4'd0, 0, 20, -1);
    tests++; if (got_d.size() != 21 || fd_cnt != 21) begin fails++; $display("FAIL sat_count: got %0d pulses %0d expected 21 21", got_d.size(), fd_cnt); end
    tests++; if (frames_played !== 4'd15) begin fails++; $display("FAIL sat_frames: got %0d expected 15", frames_played); end
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] pre;
    frame_len = 4'd2; num_frames = '0; y_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40 && frames_played < 4'd2; c++) begin
      @(posedge clk); #1;
    end
    pre = frames_played;
    #2 reset = 1'b1;
    #1;
    tests++; if (pre < 4'd2) begin fails++; $display("FAIL rst_mid_pre: frames got %0d expected >=2", pre); end
    tests++; if (y_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid_status: valid %b busy %b expected 0 0", y_valid, busy); end
    tests++; if (frames_played !== '0 || y_last !== 1'b0) begin fails++; $display("FAIL rst_mid_frames: got %0d last %b expected 0 0", frames_played, y_last); end
    y_ready = 1'b0;
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    play(4'd8, 4'd1, 0, -1, -1);
    tests++; if (got_d.size() != 8 || seq_mismatch(8) != -1) begin fails++; $display("FAIL rst_mid_replay: count %0d first %h expected 8 %h", got_d.size(), got_d.size() > 0 ? got_d[0] : 16'hxxxx, mem_m[0]); end
  endtask

  task automatic test_random();
    logic [AW:0] flen;
    logic [CW-1:0] nfr;
    int stop_at, tot, eff, mm;
    for (int it = 0; it < 10; it++) begin
      load_ram(1);
      flen = (AW+1)'($urandom_range(0, 15));
      nfr = CW'($urandom_range(0, 3));
      if (nfr == 0) stop_at = $urandom_range(0, 20);
      else stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1;
      play(flen, nfr, 2, stop_at, -1);
      eff = eff_of(flen);
      tot = exp_total(flen, nfr, stop_at);
      mm = seq_mismatch(eff);
      tests++; if (timed_out != 0 || got_d.size() != tot) begin fails++; $display("FAIL rand%0d_count: got %0d timeout %0d expected %0d 0", it, got_d.size(), timed_out, tot); end
      tests++; if (mm != -1) begin fails++; $display("FAIL rand%0d_seq: mismatch at %0d expected -1", it, mm); end
      tests++; if (int'(frames_played) != exp_frames(tot, eff)) begin fails++; $display("FAIL rand%0d_frames: got %0d expected %0d", it, frames_played, exp_frames(tot, eff)); end
      tests++; if (stable_err != 0 || fd_err != 0) begin fails++; $display("FAIL rand%0d_handshake: hold errs %0d frame_done errs %0d expected 0 0", it, stable_err, fd_err); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_multi_frame();
    test_backpressure();
    test_stop_infinite();
    test_guards();
    test_len_edges();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
